hier_color_fsm: RTL and testbench
=================================

# hier_color_fsm

Parametrised hierarchical successor to the flat colour/HSV controller. A parent FSM (BLUE, RED, HSV) sequences a nested HSV child FSM (IDLE, HUE, SAT, VAL) from a command word, with configurable data width, Moore output values and an inactivity timeout that forces the child back to the parent. The block sits between the command decoder and the pixel-mode mux, driving the mode word and a flattened state code for debug and status.

## Interface
Parameters:
- WIDTH, 2, width of `in` and `out`; must be ≥ 2.
- BLUE_VAL, 1, `out` value in BLUE; truncated to WIDTH.
- RED_VAL, 2, `out` value in RED and HSV_IDLE; truncated to WIDTH.
- TIMEOUT, 8, idle cycles allowed in any HSV child state before forced exit; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in  in  WIDTH  command word; sampled only when `in_valid`=1.
- in_valid  in  1  command strobe; one command accepted per cycle while high.
- out  out  WIDTH  Moore mode output, decoded from current state.
- state  out  3  flattened state code: BLUE=0, RED=1, HSV_IDLE=2, HSV_HUE=3, HSV_SAT=4, HSV_VAL=5.
- timeout_pulse  out  1  one-cycle flag, high in the first cycle after a forced timeout exit.

## Operation
- Commands: HOLD=0, TOGGLE=1, ENTER=2, STEP=3. Any `in` with a nonzero bit above bit 1 decodes as HOLD. When `in_valid`=0, no command is present.
- BLUE: TOGGLE -> RED; anything else stays in BLUE.
- RED: TOGGLE -> BLUE; ENTER -> HSV_IDLE; HOLD/STEP stay in RED.
- HSV_IDLE: STEP -> HSV_HUE; HOLD -> RED; TOGGLE/ENTER are ignored.
- HSV_HUE -> HSV_SAT -> HSV_VAL -> HSV_HUE on STEP (wrap); HOLD -> RED; TOGGLE/ENTER are ignored.
- `out` mapping: BLUE -> BLUE_VAL; RED and HSV_IDLE -> RED_VAL; HUE -> 1; SAT -> 2; VAL -> 3. All values are zero-extended or truncated to WIDTH.
- Idle counter, clog2(TIMEOUT) bits:
  - Cleared on entry to any HSV state.
  - Cleared on every accepted command while in HSV.
  - Increments on each cycle spent in HSV with `in_valid`=0.
  - Held at 0 outside HSV.
- Timeout: in an HSV state with `in_valid`=0 and counter == TIMEOUT-1, the next state is RED and `timeout_pulse` is registered to 1.
- Precedence: a valid command in the same cycle as a timeout wins, and no pulse is generated.
- Unreachable codes 6 and 7 recover to RED on the next edge, with `out`=RED_VAL while the illegal code is present.

## Timing
- Reset (rst=1 at an edge) gives: state=RED(1), `out`=RED_VAL, `timeout_pulse`=0, counter=0.
- Reset is honoured mid-sequence and overrides any command or timeout in the same cycle.
- Latency:
  - A command sampled at edge N changes `state` and `out` after edge N; `out` is combinational from the state register.
  - `timeout_pulse` is registered: it goes high for exactly the first cycle in which `state`=RED after a timeout, then deasserts unless a new timeout occurs.
- Timeout exit occurs TIMEOUT cycles after the last accepted HSV command, or after HSV entry, if no further command arrives.
- No handshake backpressure; every valid command is consumed in its cycle.

## Configuration
- HIER_COLOR_FSM_TIMEOUT_EN defined: the idle counter and timeout exit are compiled in as described.
- Not defined: no counter is built, HSV states wait indefinitely for HOLD, and `timeout_pulse` is tied to 0.

## Test plan
- Reset, then idle 3 cycles -> state=1, `out`=2, `timeout_pulse`=0 throughout.
- WIDTH=4, BLUE_VAL=9: TOGGLE, TOGGLE -> state 0 with `out`=9, then state 1 with `out`=2.
- ENTER, then STEP×4 -> states 2,3,4,5,3 with `out` 2,1,2,3,1; then HOLD -> state=1.
- TIMEOUT=4 with the macro defined: ENTER, STEP, then in_valid=0 -> state=3 for 4 cycles, then state=1 with `timeout_pulse`=1 for one cycle. Without the macro -> state stays at 3.
- TIMEOUT=4: STEP arrives in the exact cycle the counter reaches 3 -> state=4, no pulse, counter cleared.
- Mid-HSV (state=4): assert rst together with STEP -> state=1 next cycle, counter=0. Then `in`=4'b0110 with ENTER-like low bits -> decoded as HOLD, state stays 1.

Source files
------------

// File: rtl/hier_color_fsm.sv
// Hierarchical colour controller: parent BLUE/RED/HSV with nested HSV child
// (IDLE/HUE/SAT/VAL), Moore mode output and an optional inactivity timeout.
//
// Macro HIER_COLOR_FSM_TIMEOUT_EN: when defined, builds the idle counter and
// the forced HSV->RED exit; otherwise timeout_pulse is tied low.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in            command word (HOLD=0 TOGGLE=1 ENTER=2 STEP=3)
//   in_valid      command strobe
//   out           Moore mode word decoded from state
//   state         flattened state code (BLUE=0 .. HSV_VAL=5)
//   timeout_pulse one-cycle flag after a forced timeout exit
module hier_color_fsm #(
  parameter int WIDTH    = 2,
  parameter int BLUE_VAL = 1,
  parameter int RED_VAL  = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       state,
  output logic             timeout_pulse
);

  typedef enum logic [2:0] {
    S_BLUE = 3'd0,
    S_RED  = 3'd1,
    S_IDLE = 3'd2,
    S_HUE  = 3'd3,
    S_SAT  = 3'd4,
    S_VAL  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_HOLD   = 2'd0,
    C_TOGGLE = 2'd1,
    C_ENTER  = 2'd2,
    C_STEP   = 2'd3
  } cmd_e;

  localparam logic [WIDTH-1:0] BLUE_W = WIDTH'(BLUE_VAL);
  localparam logic [WIDTH-1:0] RED_W  = WIDTH'(RED_VAL);

  state_e state_q, state_d;
  logic   pulse_q, pulse_d;
  logic   hi_set;
  logic   in_hsv;
  cmd_e   cmd;

  // Any set bit above the 2-bit opcode field forces HOLD.
  if (WIDTH > 2) begin : g_hi
    assign hi_set = |in[WIDTH-1:2];
  end else begin : g_nohi
    assign hi_set = 1'b0;
  end

  assign cmd    = hi_set ? C_HOLD : cmd_e'(in[1:0]);
  assign in_hsv = (state_q >= S_IDLE) && (state_q <= S_VAL);

`ifdef HIER_COLOR_FSM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_hit;
  assign to_hit = in_hsv && !in_valid &&
                  (cnt_q == CW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    case (state_q)
      S_BLUE: begin
        if (in_valid && cmd == C_TOGGLE) state_d = S_RED;
      end
      S_RED: begin
        if (in_valid) begin
          if (cmd == C_TOGGLE)     state_d = S_BLUE;
          else if (cmd == C_ENTER) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          if (cmd == C_STEP)      state_d = S_HUE;
          else if (cmd == C_HOLD) state_d = S_RED;
        end
      end
      S_HUE, S_SAT, S_VAL: begin
        if (in_valid) begin
          if (cmd == C_HOLD) state_d = S_RED;
          else if (cmd == C_STEP) begin
            case (state_q)
              S_HUE:   state_d = S_SAT;
              S_SAT:   state_d = S_VAL;
              default: state_d = S_HUE;
            endcase
          end
        end
      end
      default: state_d = S_RED;
    endcase
`ifdef HIER_COLOR_FSM_TIMEOUT_EN
    // Any accepted command, or leaving HSV, clears the count.
    cnt_d = '0;
    if (to_hit) begin
      state_d = S_RED;
      pulse_d = 1'b1;
    end else if (in_hsv && !in_valid) begin
      cnt_d = cnt_q + CW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RED;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef HIER_COLOR_FSM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    out = RED_W;
    case (state_q)
      S_BLUE:  out = BLUE_W;
      S_HUE:   out = WIDTH'(1);
      S_SAT:   out = WIDTH'(2);
      S_VAL:   out = WIDTH'(3);
      default: out = RED_W;
    endcase
  end

  assign state         = state_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_hier_color_fsm.sv
// Scoreboard bench for hier_color_fsm (WIDTH=4, BLUE_VAL=9, TIMEOUT=4).
// Stimulus rows are {rst, in_valid, in[3:0]}; expected rows {state, out, pulse}.
module tb_hier_color_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_w;
  logic       in_valid;
  logic [3:0] out;
  logic [2:0] state;
  logic       timeout_pulse;

  logic [7:0] exp_q [$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hier_color_fsm #(
    .WIDTH(4), .BLUE_VAL(9), .RED_VAL(2), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .in(in_w), .in_valid(in_valid),
    .out(out), .state(state), .timeout_pulse(timeout_pulse)
  );

  function automatic logic [7:0] e(input int s, input int o, input int p);
    return {3'(s), 4'(o), 1'(p)};
  endfunction

  task automatic drive(input logic [5:0] s);
    rst      = s[5];
    in_valid = s[4];
    in_w     = s[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] s [4] = '{6'h20, 6'h00, 6'h00, 6'h00};
    logic [7:0] got, want;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e(1, 2, 0));
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL reset[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  task automatic test_toggle();
    logic [5:0] s [2] = '{6'h11, 6'h11};
    logic [7:0] x [2];
    logic [7:0] got, want;
    x = '{e(0, 9, 0), e(1, 2, 0)};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(x[i]);
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL toggle[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  task automatic test_hsv_walk();
    logic [5:0] s [6] = '{6'h12, 6'h13, 6'h13, 6'h13, 6'h13, 6'h10};
    logic [7:0] x [6];
    logic [7:0] got, want;
    x = '{e(2, 2, 0), e(3, 1, 0), e(4, 2, 0),
          e(5, 3, 0), e(3, 1, 0), e(1, 2, 0)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(x[i]);
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL hsv_walk[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [5:0] s [8] = '{6'h12, 6'h13, 6'h00, 6'h00,
                          6'h00, 6'h00, 6'h00, 6'h10};
    logic [7:0] x [8];
    logic [7:0] got, want;
`ifdef HIER_COLOR_FSM_TIMEOUT_EN
    x = '{e(2, 2, 0), e(3, 1, 0), e(3, 1, 0), e(3, 1, 0),
          e(3, 1, 0), e(1, 2, 1), e(1, 2, 0), e(1, 2, 0)};
`else
    x = '{e(2, 2, 0), e(3, 1, 0), e(3, 1, 0), e(3, 1, 0),
          e(3, 1, 0), e(3, 1, 0), e(3, 1, 0), e(1, 2, 0)};
`endif
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(x[i]);
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL timeout[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  task automatic test_step_at_timeout();
    logic [5:0] s [11] = '{6'h12, 6'h13, 6'h00, 6'h00, 6'h00, 6'h13,
                           6'h00, 6'h00, 6'h00, 6'h00, 6'h10};
    logic [7:0] x [11];
    logic [7:0] got, want;
`ifdef HIER_COLOR_FSM_TIMEOUT_EN
    x = '{e(2, 2, 0), e(3, 1, 0), e(3, 1, 0), e(3, 1, 0),
          e(3, 1, 0), e(4, 2, 0), e(4, 2, 0), e(4, 2, 0),
          e(4, 2, 0), e(1, 2, 1), e(1, 2, 0)};
`else
    x = '{e(2, 2, 0), e(3, 1, 0), e(3, 1, 0), e(3, 1, 0),
          e(3, 1, 0), e(4, 2, 0), e(4, 2, 0), e(4, 2, 0),
          e(4, 2, 0), e(4, 2, 0), e(1, 2, 0)};
`endif
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(x[i]);
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL step_at_timeout[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] s [8] = '{6'h12, 6'h13, 6'h13, 6'h33,
                          6'h16, 6'h12, 6'h17, 6'h1F};
    logic [7:0] x [8];
    logic [7:0] got, want;
    x = '{e(2, 2, 0), e(3, 1, 0), e(4, 2, 0), e(1, 2, 0),
          e(1, 2, 0), e(2, 2, 0), e(1, 2, 0), e(1, 2, 0)};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(x[i]);
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL reset_mid[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] s [15] = '{6'h11, 6'h12, 6'h13, 6'h10, 6'h01,
                           6'h11, 6'h13, 6'h12, 6'h11, 6'h12,
                           6'h01, 6'h13, 6'h11, 6'h12, 6'h10};
    logic [7:0] x [15];
    logic [7:0] got, want;
    x = '{e(0, 9, 0), e(0, 9, 0), e(0, 9, 0), e(0, 9, 0), e(0, 9, 0),
          e(1, 2, 0), e(1, 2, 0), e(2, 2, 0), e(2, 2, 0), e(2, 2, 0),
          e(2, 2, 0), e(3, 1, 0), e(3, 1, 0), e(3, 1, 0), e(1, 2, 0)};
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(x[i]);
      drive(s[i]);
      got  = {state, out, timeout_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL back_to_back[%0d] got %h want %h", i, got, want);
      else passes++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_w     = '0;
    test_reset();
    test_toggle();
    test_hsv_walk();
    test_timeout();
    test_step_at_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
